onehot_updown_counter: RTL
==========================

// Module: onehot_updown_counter
// PURPOSE
//   Bidirectional one-hot ring counter: the down-counting counterpart of the one-hot up counter.
//   A single dir input selects the count direction at run time.
//   Also supports synchronous load of a state index, a binary index output,
//   a wrap pulse and recovery from illegal (non-one-hot) states.
//   Sits behind the FSM lab front panel and drives a ledbar display and downstream binary logic.
// PARAMETERS
//   N            3   number of one-hot states / flops (N >= 2)
//   RESET_STATE  0   state index forced by reset and by illegal-state recovery (0..N-1)
//   IW           $clog2(N)  width of index ports (derived; do not override)
// PORTS
//   clock     in   1    single clock; all state updates on rising edge
//   reset_n   in   1    asynchronous, active-low reset
//   en        in   1    count enable; one step per clock while high
//   dir       in   1    0 = up (Q[i] -> Q[i+1]), 1 = down (Q[i] -> Q[i-1])
//   load      in   1    synchronous load of load_idx; takes priority over en
//   load_idx  in   IW   target state index for load
//   q         out  N    one-hot state vector (registered)
//   idx       out  IW   binary index of the hot bit (registered, always consistent with q)
//   wrap      out  1    one-cycle pulse: the ring wrapped on the previous edge
//   err       out  1    one-cycle pulse: illegal state or bad load_idx handled on the previous edge
// BEHAVIOUR
//   Reset (reset_n low, async, any time incl. mid-count): q = 1<<RESET_STATE, idx = RESET_STATE,
//     wrap = 0, err = 0. First count occurs on the first rising edge with reset_n high and en = 1.
//   Priority per edge: illegal-state recovery > load > en > hold.
//   Illegal state: q not exactly one-hot (zero or >1 bits set).
//     Next edge: q = 1<<RESET_STATE, idx = RESET_STATE, err = 1, wrap = 0; load/en ignored that cycle.
//   Load (load = 1):
//     load_idx < N:  q = 1<<load_idx, idx = load_idx, wrap = 0, err = 0.
//     load_idx >= N: state held, err = 1.
//   Count (en = 1, load = 0):
//     up:   q = rotate-left by 1; idx = (idx == N-1) ? 0 : idx+1.
//     down: q = rotate-right by 1; idx = (idx == 0) ? N-1 : idx-1.
//     wrap = 1 iff the step crossed the ring boundary (up: N-1 -> 0; down: 0 -> N-1); else 0.
//   Hold (en = 0, load = 0, legal state): q and idx unchanged, wrap = 0, err = 0.
//   Latency: q/idx/wrap/err all update on the same edge; one-cycle latency from inputs.
//     wrap and err are never high for two consecutive cycles unless the triggering condition repeats.
//   dir may change on any cycle; it takes effect on the next enabled edge. No glitching of q between edges.
//   idx is registered alongside q (not decoded combinationally); idx must equal the position of the hot bit in q every cycle.
// TESTING
//   Reset then en = 1, dir = 0 for 4 edges (N = 3) -> q = 001, 010, 100, 001, 010; wrap high only after the 3rd edge.
//   From q = 001, en = 1, dir = 1 for 3 edges -> q = 100 (wrap = 1), 010, 001; idx = 2, 1, 0.
//   Alternate dir every cycle from q = 010 with en = 1 -> q = 100, 010, 100, 010; no wrap.
//   load = 1, load_idx = 2 with en = 1 -> q = 100, idx = 2, wrap = 0.
//   load = 1, load_idx = 3 -> q held, err = 1 for exactly one cycle.
//   Force q = 011 via the bench, then one edge -> q = 001, idx = 0, err = 1.
//   Assert reset_n low between edges mid-count -> q = 001 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_updown_counter.sv
// Bidirectional one-hot ring counter with synchronous index load, registered binary index,
// wrap/err pulses and recovery from illegal (non-one-hot) states.
module onehot_updown_counter #(
  parameter int N           = 3,
  parameter int RESET_STATE = 0,
  localparam int IW         = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  output logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          err
);

  localparam logic [N-1:0]  ONE        = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  RST_Q      = ONE << RESET_STATE;
  localparam logic [IW-1:0] RST_IDX    = IW'(RESET_STATE);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [IW:0]   NUM_STATES = (IW + 1)'(N);

  logic [N-1:0]  r_q;
  logic [IW-1:0] r_idx;
  logic          r_wrap;
  logic          r_err;

  logic [N-1:0]  w_nextQ;
  logic [IW-1:0] w_nextIdx;
  logic          w_nextWrap;
  logic          w_nextErr;
  logic          w_legal;
  logic          w_loadOk;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_legal  = (r_q != '0) && ((r_q & (r_q - ONE)) == '0);
  assign w_loadOk = ({1'b0, load_idx} < NUM_STATES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= RST_Q;
      r_idx  <= RST_IDX;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_q    <= w_nextQ;
      r_idx  <= w_nextIdx;
      r_wrap <= w_nextWrap;
      r_err  <= w_nextErr;
    end
  end

  // The index is advanced in step with the ring rather than decoded from it, so both move together.
  always_comb begin
    w_nextQ    = r_q;
    w_nextIdx  = r_idx;
    w_nextWrap = 1'b0;
    w_nextErr  = 1'b0;
    if (!w_legal) begin
      w_nextQ   = RST_Q;
      w_nextIdx = RST_IDX;
      w_nextErr = 1'b1;
    end else if (load) begin
      if (w_loadOk) begin
        w_nextQ   = ONE << load_idx;
        w_nextIdx = load_idx;
      end else begin
        w_nextErr = 1'b1;
      end
    end else if (en) begin
      if (!dir) begin
        w_nextQ    = {r_q[N-2:0], r_q[N-1]};
        w_nextIdx  = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        w_nextWrap = (r_idx == LAST_IDX);
      end else begin
        w_nextQ    = {r_q[0], r_q[N-1:1]};
        w_nextIdx  = (r_idx == '0) ? LAST_IDX : r_idx - IW'(1);
        w_nextWrap = (r_idx == '0);
      end
    end
  end

  assign q    = r_q;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
